instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
- IF stage and IF/ID pipeline register of the 5-stage pipelined MIPS CPU; sits directly upstream of the decode stage.
- On start, captures the packed program bundle into an internal instruction ROM.
- Each cycle, fetches the word addressed by PC and presents it to decode with PC and PC+4.
- Applies stall, flush and branch-redirect requests coming from the hazard and branch logic downstream.

Parameters:
- NUM_INSTR, 10, number of 32-bit instruction slots in the program bundle.
- INSTR_W, 32, instruction width in bits.
- DRAIN_CYCLES, 4, bubble cycles issued after the last fetch so downstream stages empty before done.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load program and begin fetching; sampled only in IDLE or DONE.
- in_instruction  in  NUM_INSTR*INSTR_W  program bundle; slot k (address 4k) = bits [NUM_INSTR*32-1-32k -: 32]; slot 0 is the MSBs.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  squash the IF/ID entry (write a bubble).
- branch_taken  in  1  redirect PC to branch_target.
- branch_target  in  32  byte address of the redirect; bits [1:0] are ignored.
- if_id_valid  out  1  IF/ID entry holds a real instruction.
- if_id_instruction  out  32  fetched instruction; 0 when invalid.
- if_id_pc  out  32  byte address of if_id_instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4.
- PC  out  32  current fetch address.
- busy  out  1  high in LOAD, FETCH and DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State is IDLE.
  - PC, if_id_instruction, if_id_pc and if_id_pc_plus4 are 0.
  - if_id_valid, busy and done are 0.
  - ROM contents are cleared to 0.
  - Reset mid-operation aborts the program immediately; no partial state survives.
- States:
  - IDLE: waits. start=1 goes to LOAD.
  - LOAD: one cycle. Copies in_instruction into the ROM, sets PC=0, keeps IF/ID invalid, then goes to FETCH.
  - FETCH: on each non-stalled cycle:
    - if_id_instruction <= ROM[PC[31:2]], if_id_pc <= PC, if_id_pc_plus4 <= PC+4, if_id_valid <= 1, PC <= PC+4.
    - If PC >= NUM_INSTR*4, no fetch occurs: IF/ID gets a bubble (valid 0, instruction 0), PC holds, drain counter loads DRAIN_CYCLES-1, and state goes to DRAIN.
  - DRAIN: IF/ID carries a bubble each cycle. The counter decrements on every cycle, including stalled cycles. At 0 the state goes to DONE.
  - DONE: done=1, IF/ID invalid, PC holds. start=1 goes to LOAD (rerun with a fresh bundle).
- start is ignored in LOAD, FETCH and DRAIN.
- Same-cycle priority in FETCH and DRAIN: branch_taken > flush > stall > normal fetch.
  - branch_taken: PC <= {branch_target[31:2],2'b00}; IF/ID <= bubble.
    - In DRAIN, a target below NUM_INSTR*4 returns the state to FETCH.
    - An out-of-range target enters, or stays in, DRAIN on the next fetch attempt.
  - flush without branch: IF/ID <= bubble; PC advances as in a normal fetch.
  - stall only: PC and all IF/ID outputs hold their values.
- Fetch latency: the word at PC appears on if_id_* one cycle after the fetching edge. The first valid instruction is visible 2 cycles after start is sampled.
- Arithmetic: PC+4 is a 32-bit add with natural wrap. No exception on wrap; the out-of-range check catches it.
- All outputs are registered; none depends combinationally on inputs.

Test Plan:
- Reset then start with the 10-slot bundle, slot 0 = 0xAC000000, slot 1 = 0x8C010000 → cycle after LOAD: if_id_instruction=0xAC000000, if_id_pc=0, if_id_pc_plus4=4, valid=1. Next cycle: 0x8C010000, pc=4. PC then steps by 4 up to 0x28.
- Straight run of 10 slots → after pc=0x24 is fetched, exactly 4 bubble cycles occur, then done=1, busy=0. Re-assert start → LOAD again, first fetch from pc=0.
- stall held 3 cycles while if_id_pc=8 → PC=0xC and IF/ID frozen for 3 cycles. The fetch resumes with pc=0xC and no instruction is lost or duplicated.
- branch_taken with target 0x05 while PC=0x14 and stall=1 in the same cycle → next cycle IF/ID is a bubble and PC=0x04. The following valid fetch is slot 1 with pc=4.
- flush alone at PC=0x10 → IF/ID bubble, PC=0x14. Next valid fetch shows pc=0x14.
- rst_n pulled low mid-FETCH at PC=0x18 → all outputs 0 asynchronously and state IDLE. After release, no fetch happens until start; ROM reads as 0 until reloaded.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// IF stage plus IF/ID pipeline register: loads a packed program into a small ROM,
// then fetches one word per cycle, honouring branch redirect, flush and stall.
module instr_fetch_stage #(
    parameter int NUM_INSTR    = 10,
    parameter int INSTR_W      = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_INSTR*INSTR_W-1:0]  in_instruction,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    output logic                          if_id_valid,
    output logic [INSTR_W-1:0]            if_id_instruction,
    output logic [31:0]                   if_id_pc,
    output logic [31:0]                   if_id_pc_plus4,
    output logic [31:0]                   PC,
    output logic                          busy,
    output logic                          done
);

    localparam logic [31:0] PC_LIMIT = 32'(NUM_INSTR * 4);
    localparam int          CNT_W    = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   drain_cnt_reg;
    logic [INSTR_W-1:0] rom_mem     [NUM_INSTR];
    logic [INSTR_W-1:0] bundle_slot [NUM_INSTR];
    logic [INSTR_W-1:0] rom_rdata;
    logic [31:0]        pc_plus4;
    logic [31:0]        redirect_pc;
    logic               pc_in_range;
    logic               target_in_range;

    // Slot 0 sits in the most significant word of the bundle.
    generate
        for (genvar gi = 0; gi < NUM_INSTR; gi++) begin : g_slot
            assign bundle_slot[gi] =
                in_instruction[NUM_INSTR*INSTR_W-1-INSTR_W*gi -: INSTR_W];
        end
    endgenerate

    assign pc_plus4        = PC + 32'd4;
    assign redirect_pc     = branch_target & ~32'h3;
    assign pc_in_range     = (PC < PC_LIMIT);
    assign target_in_range = (redirect_pc < PC_LIMIT);

    always_comb begin
        rom_rdata = '0;
        for (int k = 0; k < NUM_INSTR; k++) begin
            if (PC[31:2] == 30'(k)) begin
                rom_rdata = rom_mem[k];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_INSTR; k++) begin
                rom_mem[k] <= '0;
            end
        end else if (state_reg == S_LOAD) begin
            for (int k = 0; k < NUM_INSTR; k++) begin
                rom_mem[k] <= bundle_slot[k];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= S_IDLE;
            drain_cnt_reg     <= '0;
            PC                <= '0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= '0;
            if_id_pc          <= '0;
            if_id_pc_plus4    <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_LOAD;
                        busy      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    PC                <= '0;
                    if_id_valid       <= 1'b0;
                    if_id_instruction <= '0;
                    state_reg         <= S_FETCH;
                end

                S_FETCH: begin
                    if (branch_taken) begin
                        PC                <= redirect_pc;
                        if_id_valid       <= 1'b0;
                        if_id_instruction <= '0;
                    end else if (flush) begin
                        if_id_valid       <= 1'b0;
                        if_id_instruction <= '0;
                        if (pc_in_range) begin
                            PC <= pc_plus4;
                        end else begin
                            drain_cnt_reg <= CNT_W'(DRAIN_CYCLES - 1);
                            state_reg     <= S_DRAIN;
                        end
                    end else if (stall) begin
                        // Hold PC and the IF/ID register untouched.
                    end else if (pc_in_range) begin
                        if_id_valid       <= 1'b1;
                        if_id_instruction <= rom_rdata;
                        if_id_pc          <= PC;
                        if_id_pc_plus4    <= pc_plus4;
                        PC                <= pc_plus4;
                    end else begin
                        if_id_valid       <= 1'b0;
                        if_id_instruction <= '0;
                        drain_cnt_reg     <= CNT_W'(DRAIN_CYCLES - 1);
                        state_reg         <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // The counter keeps running under stall; only an in-range
                    // redirect pulls the stage back into fetching.
                    if_id_valid       <= 1'b0;
                    if_id_instruction <= '0;
                    if (branch_taken) begin
                        PC <= redirect_pc;
                    end
                    if (branch_taken && target_in_range) begin
                        state_reg <= S_FETCH;
                    end else if (drain_cnt_reg == '0) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 1'b1;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        state_reg <= S_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
